// File: rtl/fft_pkg.sv
// Shared types and width helpers for the FFT frame capture path.
package fft_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_e;

  function automatic int mag_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Squared-magnitude pipeline: the squares are registered here, and their sum
// is handed out combinationally to be registered by the frame buffer and peak logic.
module fft_mag_sq import fft_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_i,
  input  logic signed [DATA_W-1:0]     re_i,
  input  logic signed [DATA_W-1:0]     im_i,
  input  logic [IDX_W-1:0]             idx_i,
  output logic                         vld_o,
  output logic [IDX_W-1:0]             idx_o,
  output logic [mag_w(DATA_W)-1:0]     mag_o
);
  localparam int MAG_W = mag_w(DATA_W);

  logic signed [2*DATA_W-1:0] re_x, im_x;
  logic [2*DATA_W-1:0]        sq_re_q, sq_im_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       vld_q;

  assign re_x = (2*DATA_W)'(re_i);
  assign im_x = (2*DATA_W)'(im_i);

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_i;
  end

  always_ff @(posedge clk) begin
    sq_re_q <= $unsigned(re_x * re_x);
    sq_im_q <= $unsigned(im_x * im_x);
    idx_q   <= idx_i;
  end

  // One extra bit makes the sum of two full-scale squares overflow-free.
  assign mag_o = MAG_W'(sq_re_q) + MAG_W'(sq_im_q);
  assign vld_o = vld_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/fft_frame_capture.sv
// Captures one FFT output frame as squared magnitudes into a readable buffer,
// tracking the peak bin and flagging frames of the wrong length.
module fft_frame_capture import fft_pkg::*; #(
  parameter int N_POINTS = 1024,
  parameter int DATA_W   = 16,
  localparam int MAG_W   = mag_w(DATA_W),
  localparam int IDX_W   = idx_w(N_POINTS)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     arm,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_re,
  input  logic signed [DATA_W-1:0] s_im,
  input  logic                     s_last,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic [MAG_W-1:0]         rd_data,
  output logic                     done,
  output logic [IDX_W-1:0]         peak_bin,
  output logic [MAG_W-1:0]         peak_mag,
  output logic                     err_len
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  peak_bin_q;
  logic [MAG_W-1:0]  peak_mag_q;
  logic [MAG_W-1:0]  rd_data_q;
  logic [MAG_W-1:0]  mem_q [N_POINTS];

  logic              accept, last_idx;
  logic              mag_vld;
  logic [IDX_W-1:0]  mag_idx;
  logic [MAG_W-1:0]  mag;

  assign s_ready  = (state_q == ARMED) || (state_q == CAPTURE);
  assign accept   = s_valid && s_ready;
  assign last_idx = (cnt_q == LAST_IDX);

  fft_mag_sq #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_mag (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .vld_i (accept),
    .re_i  (s_re),
    .im_i  (s_im),
    .idx_i (cnt_q),
    .vld_o (mag_vld),
    .idx_o (mag_idx),
    .mag_o (mag)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        cnt_d = '0;
        if (arm) begin
          state_d = ARMED;
          err_d   = 1'b0;
        end
      end
      ARMED, CAPTURE: begin
        if (accept) begin
          cnt_d   = cnt_q + IDX_W'(1);
          state_d = CAPTURE;
          if (s_last || last_idx) begin
            state_d = DRAIN;
            err_d   = s_last ^ last_idx;
          end
        end
      end
      // Stage-2 commits happen on the edge where stage 1 empties.
      DRAIN: if (!mag_vld) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Bin 0 always loads, so ties resolve to the lowest index.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_q == ARMED) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else if (mag_vld && (mag_idx == '0 || mag > peak_mag_q)) begin
      peak_bin_q <= mag_idx;
      peak_mag_q <= mag;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mag_vld) mem_q[mag_idx] <= mag;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rd_data_q <= '0;
    else         rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data  = rd_data_q;
  assign done     = (state_q == DONE);
  assign peak_bin = peak_bin_q;
  assign peak_mag = peak_mag_q;
  assign err_len  = err_q;

endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed bench for fft_frame_capture with an 8-bin frame.
module tb_fft_frame_capture;
  localparam int N  = 8;
  localparam int DW = 16;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b1;
  logic                 arm = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_re = '0;
  logic signed [DW-1:0] s_im = '0;
  logic                 s_last = 1'b0;
  logic [2:0]           rd_addr = '0;
  logic [2*DW:0]        rd_data;
  logic                 done;
  logic [2:0]           peak_bin;
  logic [2*DW:0]        peak_mag;
  logic                 err_len;

  logic signed [DW-1:0] vre [N];
  logic signed [DW-1:0] vim [N];
  int n_chk = 0;
  int n_err = 0;

  fft_frame_capture #(.N_POINTS(N), .DATA_W(DW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .arm(arm),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .s_last(s_last), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .err_len(err_len)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drive n beats from vre/vim; s_last on beat last_at (-1 = never).
  task automatic run_frame(input int n, input int last_at, input int gap, input int arm_at);
    for (int k = 0; k < n; k++) begin
      int w;
      s_valid = 1'b1;
      s_re    = vre[k];
      s_im    = vim[k];
      s_last  = (k == last_at);
      arm     = (k == arm_at);
      w = 0;
      while (!s_ready && w < 20) begin
        tick();
        w++;
      end
      if (w == 20) chk("accept_timeout", 0, 1);
      tick();
      arm     = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (gap != 0 && k < n - 1) tick();
    end
  endtask

  // Called one cycle after the final accepted beat.
  task automatic chk_end(input string tag, input logic exp_err);
    chk({tag, "_ready_fall"}, s_ready, 0);
    tick();
    chk({tag, "_done_t2"}, done, 0);
    tick();
    chk({tag, "_done_t3"}, done, 1);
    chk({tag, "_err_len"}, err_len, exp_err);
  endtask

  task automatic rd_chk(input string tag, input int a, input longint exp);
    rd_addr = 3'(a);
    tick();
    chk(tag, rd_data, exp);
  endtask

  function automatic longint msq(input int k);
    return longint'(vre[k]) * longint'(vre[k]) + longint'(vim[k]) * longint'(vim[k]);
  endfunction

  initial begin
    tick();
    tick();
    sys_rst = 1'b0;
    chk("rst_ready", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_len, 0);
    chk("rst_peak_bin", peak_bin, 0);
    chk("rst_peak_mag", peak_mag, 0);
    chk("rst_rd_data", rd_data, 0);

    // Ramp frame, back to back
    for (int k = 0; k < N; k++) begin vre[k] = DW'(k); vim[k] = '0; end
    pulse_arm();
    chk("arm_ready", s_ready, 1);
    run_frame(N, N - 1, 0, -1);
    chk_end("ramp", 0);
    chk("ramp_peak_bin", peak_bin, 7);
    chk("ramp_peak_mag", peak_mag, 49);
    for (int k = 0; k < N; k++) rd_chk("ramp_rd", k, longint'(k * k));

    // Equal magnitudes: lower index wins; arm in DONE clears done
    for (int k = 0; k < N; k++) begin vre[k] = '0; vim[k] = '0; end
    vre[2] = 3; vim[2] = 4; vre[5] = -5;
    pulse_arm();
    chk("rearm_done_clr", done, 0);
    run_frame(N, N - 1, 0, -1);
    chk_end("tie", 0);
    chk("tie_peak_bin", peak_bin, 2);
    chk("tie_peak_mag", peak_mag, 25);
    rd_chk("tie_rd2", 2, 25);
    rd_chk("tie_rd5", 5, 25);
    rd_chk("tie_rd7", 7, 0);

    // Full-scale bin, with arm pulsed mid-capture (ignored)
    for (int k = 0; k < N; k++) begin vre[k] = 1; vim[k] = 1; end
    vre[3] = -32768; vim[3] = -32768;
    pulse_arm();
    run_frame(N, N - 1, 0, 4);
    chk_end("ext", 0);
    chk("ext_peak_bin", peak_bin, 3);
    chk("ext_peak_mag", peak_mag, 64'd2147483648);
    rd_chk("ext_rd3", 3, 64'd2147483648);
    rd_chk("ext_rd6", 6, 2);

    // Ramp again with s_valid toggling
    for (int k = 0; k < N; k++) begin vre[k] = DW'(k); vim[k] = '0; end
    pulse_arm();
    run_frame(N, N - 1, 1, -1);
    chk_end("gap", 0);
    for (int k = 0; k < N; k++) rd_chk("gap_rd", k, msq(k));

    // Short frame: s_last on beat 4, upper bins stay stale
    for (int k = 0; k < N; k++) begin vre[k] = DW'(10 + k); vim[k] = '0; end
    pulse_arm();
    run_frame(5, 4, 0, -1);
    chk_end("short", 1);
    chk("short_peak_bin", peak_bin, 4);
    chk("short_peak_mag", peak_mag, 196);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("short_no_accept", s_ready, 0);
      tick();
    end
    s_valid = 1'b0;
    rd_chk("short_rd4", 4, 196);
    rd_chk("short_rd5", 5, 25);

    // No s_last: frame ends at beat 7, surplus beat held off
    for (int k = 0; k < N; k++) begin vre[k] = DW'(k); vim[k] = 2; end
    pulse_arm();
    run_frame(N, -1, 0, -1);
    s_valid = 1'b1;
    chk_end("nolast", 1);
    chk("nolast_hold", s_ready, 0);
    s_valid = 1'b0;
    rd_chk("nolast_rd7", 7, 53);

    // Reset mid-frame, then a clean frame
    for (int k = 0; k < N; k++) begin vre[k] = DW'(7 - k); vim[k] = '0; end
    pulse_arm();
    run_frame(3, -1, 0, -1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("mrst_ready", s_ready, 0);
    chk("mrst_done", done, 0);
    chk("mrst_peak_mag", peak_mag, 0);
    chk("mrst_err", err_len, 0);
    tick(); tick(); tick();
    chk("mrst_no_done", done, 0);
    pulse_arm();
    run_frame(N, N - 1, 0, -1);
    chk_end("post_rst", 0);
    chk("post_rst_peak_bin", peak_bin, 0);
    chk("post_rst_peak_mag", peak_mag, 49);
    rd_chk("post_rst_rd0", 0, 49);
    rd_chk("post_rst_rd3", 3, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_capture.md
# fft_frame_capture

Receiving end of the FFT data path. It accepts one streamed FFT output frame (complex bins, valid/ready with a last marker) after an arm pulse. Each bin's squared magnitude is computed in a two-stage pipeline and written to an internal frame buffer, and the peak bin is tracked. When the frame is complete the block raises `done` and the buffer can be read back by bin index. It sits downstream of the FFT core and upstream of display or measurement logic, and is triggered by the same single-cycle `data_flag`-style strobe that launches a transform.

## Interface
- `N_POINTS`, default 1024: bins per frame; must be a power of two, at least 8.
- `DATA_W`, default 16: signed width of the real and imaginary parts.
- `MAG_W`, default 2*DATA_W+1: width of the squared magnitude; derived, not overridden.
- `sys_clk` in 1: the single clock; all logic is on the rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `arm` in 1: single-cycle strobe that starts a capture.
- `s_valid` in 1: input bin is valid.
- `s_ready` out 1: block accepts a bin.
- `s_re` in DATA_W: signed real part.
- `s_im` in DATA_W: signed imaginary part.
- `s_last` in 1: marks the final bin of the frame.
- `rd_addr` in log2(N_POINTS): buffer read index.
- `rd_data` out MAG_W: squared magnitude at `rd_addr`, registered.
- `done` out 1: frame captured; buffer and peak outputs are valid.
- `peak_bin` out log2(N_POINTS): index of the largest magnitude.
- `peak_mag` out MAG_W: the largest magnitude.
- `err_len` out 1: the frame length was not N_POINTS.

## Operation
- Reset values: `s_ready`=0, `done`=0, `err_len`=0, `peak_bin`=0, `peak_mag`=0, `rd_data`=0. The state machine goes to IDLE and the pipeline valids clear. Buffer contents are undefined.
- States:
  - IDLE: `arm` moves to ARMED.
  - ARMED: `s_ready`=1. Bin counter, peak and `err_len` are cleared. The first accepted beat moves to CAPTURE.
  - CAPTURE: `s_ready`=1 and every accepted beat increments the bin counter. The frame ends on the beat carrying `s_last`, or on beat N_POINTS-1, whichever comes first. At frame end the state moves to DRAIN.
  - DRAIN: `s_ready`=0 while the two pipeline stages empty. Then the state moves to DONE.
  - DONE: `done`=1. `arm` clears `done` and moves to ARMED.
- A beat is accepted only when `s_valid` and `s_ready` are both high. Beats presented in IDLE, DRAIN or DONE are not accepted and not consumed.
- `arm` is ignored in ARMED, CAPTURE and DRAIN.
- Length check:
  - `s_last` on a beat with index other than N_POINTS-1 sets `err_len` and ends the frame. Unwritten bins keep stale contents.
  - Beat N_POINTS-1 without `s_last` sets `err_len` and ends the frame. The surplus upstream beats are left unaccepted.
- Arithmetic:
  - Stage 1 registers the signed squares re² and im², each 2*DATA_W bits and unsigned-valued.
  - Stage 2 registers their sum at MAG_W bits, with no overflow. Example: (-32768)²+(-32768)² = 2³¹ fits in 33 bits.
- Buffer write happens at stage 2, addressed by the bin index carried down the pipeline.
- Peak update happens at stage 2. The peak is replaced only if the new value is strictly greater, so on ties the lowest index wins. The first bin of a frame always loads the peak.
- Reads:
  - `rd_data` updates one cycle after `rd_addr`, in every state.
  - Reads are only meaningful while `done`=1.
  - A read of the address being written in the same cycle returns the old data.
- A synchronous reset mid-frame aborts the capture immediately with the reset values above. No partial `done` is produced.

## Timing
- Let t be the cycle in which a beat is accepted. Its stage-1 result is registered at the end of t, and its magnitude is written to the buffer and compared with the peak at the end of t+1.
- If the final beat is accepted in cycle t:
  - `s_ready` falls in t+1.
  - `done`, `peak_bin`, `peak_mag` and `err_len` are valid from t+3.
- Throughput is one bin per cycle with no bubbles required.
- After `arm` in IDLE or DONE, `s_ready` rises the next cycle.

## Structure
- Shared package `fft_pkg`:
  - the state enum (IDLE, ARMED, CAPTURE, DRAIN, DONE);
  - a function for the MAG_W derivation;
  - the clog2 index width helper.
- Sub-module `fft_mag_sq`: the two-stage squared-magnitude pipeline. It carries the valid bit and bin index alongside the data.
- The frame buffer is a simple dual-port RAM with one write port and one registered read port, inferred in place.

## Test plan
Run with N_POINTS=8 and DATA_W=16.
- Reset, then `arm`, then 8 back-to-back bins with re=k, im=0 for k=0..7 and `s_last` on k=7. Required response: `done` at t+3 after the last beat, `peak_bin`=7, `peak_mag`=49, `err_len`=0, and reads of addresses 0..7 return k² one cycle after `rd_addr`.
- Bins with (3,4) at index 2 and (-5,0) at index 5, all others 0. Required response: equal magnitudes of 25, so `peak_bin`=2; extreme bin (-32768,-32768) reads back 2147483648.
- `s_valid` toggled every other cycle over a full frame. Required response: the same buffer contents as the back-to-back case, and `done` at the same t+3 offset from the last accepted beat.
- `s_last` on beat 4. Required response: `err_len`=1, `done` asserts, no further beats accepted. Separately, a frame with no `s_last`: `err_len`=1 after beat 7 and `s_ready` low from the next cycle.
- `sys_rst` pulsed after 3 beats, then `arm` and a full frame. Required response: no `done` before the new frame; the second frame captures correctly with `err_len`=0.
- `arm` pulsed mid-capture. Required response: ignored. `arm` in DONE: `done` clears the next cycle and a second frame overwrites the buffer and peak.
